// File: rtl/acc.sv
// Phase accumulator for the oscillator voice: adds freq to a wrapping phase once every DIV clocks.
// Latency: one clock from the stepping edge to waveOut/ovf; free-running, no backpressure.
module acc #(
  parameter int ACC_W  = 24,
  parameter int FREQ_W = 12,
  parameter int DIV    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W-1:0] freq,
  output logic [ACC_W-1:0]  waveOut,
  output logic              ovf
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] count;
  logic             en;
  logic [ACC_W:0]   sum;

  assign en  = (count == CNT_W'(DIV - 1));
  // Extra top bit captures the carry out of the phase register
  assign sum = {1'b0, waveOut} + (ACC_W + 1)'(freq);

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      waveOut <= '0;
      ovf     <= 1'b0;
    end else if (en) begin
      count   <= '0;
      waveOut <= sum[ACC_W-1:0];
      ovf     <= sum[ACC_W];
    end else begin
      count   <= count + 1'b1;
      ovf     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc.sv
// Directed self-checking bench for acc: one instance at DIV=1, one at DIV=4.
module tb_acc;

  logic        clk;
  logic        rst;
  logic [11:0] freq;
  logic [23:0] wave;
  logic        ovf;

  logic        rst4;
  logic [11:0] freq4;
  logic [23:0] wave4;
  logic        ovf4;

  int n_chk;
  int n_pass;
  int cyc;

  acc #(.ACC_W(24), .FREQ_W(12), .DIV(1)) dut (
    .clk(clk), .rst(rst), .freq(freq), .waveOut(wave), .ovf(ovf)
  );

  acc #(.ACC_W(24), .FREQ_W(12), .DIV(4)) dut4 (
    .clk(clk), .rst(rst4), .freq(freq4), .waveOut(wave4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic do_reset4();
    rst4 = 1'b1;
    step(1);
    rst4 = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    freq   = 12'd114;
    rst4   = 1'b1;
    freq4  = 12'd10;

    // Reset state, then 3 steps of 114
    step(1);
    chk("rst_wave", wave, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    step(3);
    chk("three_steps", wave, 342);
    step(2);
    chk("five_steps", wave, 570);
    do_reset();
    chk("midrun_rst_wave", wave, 0);
    chk("midrun_rst_ovf", ovf, 0);
    step(3);
    chk("after_rst_three", wave, 342);

    // Exact full scale with 0xFFF: 4097 steps land on 0xFFFFFF without a wrap
    freq = 12'hFFF;
    do_reset();
    step(4096);
    chk("fs_4096", wave, 16773120);
    step(1);
    chk("fs_4097_wave", wave, 24'hFFFFFF);
    chk("fs_4097_ovf", ovf, 0);
    step(1);
    chk("fs_4098_wave", wave, 4094);
    chk("fs_4098_ovf", ovf, 1);
    step(1);
    chk("fs_4099_wave", wave, 8189);
    chk("fs_4099_ovf", ovf, 0);

    // Approach wrap with 0xFFF, then count steps of 114 until the carry strobe
    freq = 12'hFFF;
    do_reset();
    step(4096);
    freq = 12'd114;
    cyc = 0;
    while (ovf !== 1'b1 && cyc < 100) begin
      step(1);
      cyc++;
    end
    chk("wrap_cycles", cyc, 36);
    chk("wrap_wave", wave, 8);
    step(1);
    chk("wrap_ovf_one_cycle", ovf, 0);
    chk("wrap_next_wave", wave, 122);

    // freq=0 hold at phase 1000
    freq = 12'd100;
    do_reset();
    step(10);
    chk("load_1000", wave, 1000);
    freq = 12'd0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("hold_wave", wave, 1000);
      chk("hold_ovf", ovf, 0);
    end

    // Mid-run frequency change
    freq = 12'd100;
    do_reset();
    step(5);
    chk("chg_500", wave, 500);
    freq = 12'd1;
    step(1);
    chk("chg_501", wave, 501);

    // Reset on the edge that would otherwise wrap
    freq = 12'hFFF;
    do_reset();
    step(4097);
    chk("prewrap_wave", wave, 24'hFFFFFF);
    do_reset();
    chk("rst_wrap_wave", wave, 0);
    chk("rst_wrap_ovf", ovf, 0);
    step(1);
    chk("post_rst_wave", wave, 4095);
    chk("post_rst_ovf", ovf, 0);

    // Prescaler DIV=4: steps on every 4th edge after reset
    freq4 = 12'd10;
    do_reset4();
    chk("div4_rst", wave4, 0);
    for (int e = 1; e <= 8; e++) begin
      step(1);
      chk("div4_wave", wave4, (e / 4) * 10);
      chk("div4_ovf", ovf4, 0);
    end

    // DIV=4 wrap: ovf only on the stepping edge
    freq4 = 12'hFFF;
    do_reset4();
    step(4097 * 4);
    chk("div4_fs_wave", wave4, 24'hFFFFFF);
    chk("div4_fs_ovf", ovf4, 0);
    for (int e = 1; e <= 3; e++) begin
      step(1);
      chk("div4_gap_wave", wave4, 24'hFFFFFF);
      chk("div4_gap_ovf", ovf4, 0);
    end
    step(1);
    chk("div4_wrap_wave", wave4, 4094);
    chk("div4_wrap_ovf", ovf4, 1);
    step(1);
    chk("div4_after_wave", wave4, 4094);
    chk("div4_after_ovf", ovf4, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
